// File: rtl/mem2apb_pkg.sv
// Shared types and constants for the mem->APB4 bridge with address-mapped slave mux.
package mem2apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10,
      RESP   = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,
      ERR_DEC  = 2'b01,
      ERR_SLV  = 2'b10,
      ERR_TMO  = 2'b11
   } err_code_e;

   localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem2apb_addr_dec.sv
// Combinational base/mask address decoder; the lowest-index matching slave wins.
module mem2apb_addr_dec #(
   parameter int unsigned                        SLV_NUM  = 8,
   parameter int unsigned                        ADDR_W   = 32,
   parameter int unsigned                        IDX_W    = 3,
   parameter logic [SLV_NUM-1:0][ADDR_W-1:0]     SLV_BASE = '0,
   parameter logic [SLV_NUM-1:0][ADDR_W-1:0]     SLV_MASK = '0
) (
   input  logic [ADDR_W-1:0]  addr,
   output logic               hit,
   output logic [SLV_NUM-1:0] sel,
   output logic [IDX_W-1:0]   idx
);

   always_comb begin
      hit = 1'b0;
      sel = '0;
      idx = '0;
      for (int unsigned i = 0; i < SLV_NUM; i++) begin
         if (!hit && ((addr & SLV_MASK[i]) == SLV_BASE[i])) begin
            hit    = 1'b1;
            sel[i] = 1'b1;
            idx    = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/mem2apb_bridge_mux.sv
// picorv32-style mem request to APB4 bridge over SLV_NUM slaves, with decode-miss,
// PSLVERR and PREADY-timeout error reporting plus sticky error capture.
module mem2apb_bridge_mux
   import mem2apb_pkg::*;
#(
   parameter int unsigned                    SLV_NUM     = 8,
   parameter int unsigned                    ADDR_W      = 32,
   parameter int unsigned                    DATA_W      = 32,
   parameter logic [SLV_NUM-1:0][ADDR_W-1:0] SLV_BASE    = '0,
   parameter logic [SLV_NUM-1:0][ADDR_W-1:0] SLV_MASK    = '0,
   parameter int unsigned                    TIMEOUT_CYC = 255,
   parameter logic [DATA_W-1:0]              ERR_RDATA   = DATA_W'(DEF_ERR_RDATA)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      mem_valid_i,
   input  logic [ADDR_W-1:0]         mem_addr_i,
   input  logic [DATA_W-1:0]         mem_wdata_i,
   input  logic [DATA_W/8-1:0]       mem_wstrb_i,
   output logic [DATA_W-1:0]         mem_rdata_o,
   output logic                      mem_ready_o,
   output logic                      mem_err_o,
   output logic [ADDR_W-1:0]         apb_paddr_o,
   output logic [2:0]                apb_pprot_o,
   output logic [SLV_NUM-1:0]        apb_psel_o,
   output logic                      apb_penable_o,
   output logic                      apb_pwrite_o,
   output logic [DATA_W-1:0]         apb_pwdata_o,
   output logic [DATA_W/8-1:0]       apb_pstrb_o,
   input  logic [SLV_NUM-1:0]        apb_pready_i,
   input  logic [SLV_NUM*DATA_W-1:0] apb_prdata_i,
   input  logic [SLV_NUM-1:0]        apb_pslverr_i,
   output logic [1:0]                err_code_o,
   output logic [ADDR_W-1:0]         err_addr_o,
   output logic                      err_irq_o
);

   localparam int unsigned IDX_W  = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
   localparam int unsigned TMO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int unsigned STRB_W = DATA_W / 8;

   state_e              state_q, state_d;
   logic [SLV_NUM-1:0]  sel_q, sel_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [STRB_W-1:0]   pstrb_q, pstrb_d;
   logic                pwrite_q, pwrite_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   err_code_e           err_code_q, err_code_d;
   logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

   logic                dec_hit;
   logic [SLV_NUM-1:0]  dec_sel;
   logic [IDX_W-1:0]    dec_idx;
   logic                slv_ready;
   logic                slv_err;
   logic [DATA_W-1:0]   slv_rdata;

   mem2apb_addr_dec #(
      .SLV_NUM  (SLV_NUM),
      .ADDR_W   (ADDR_W),
      .IDX_W    (IDX_W),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_addr_dec (
      .addr (mem_addr_i),
      .hit  (dec_hit),
      .sel  (dec_sel),
      .idx  (dec_idx)
   );

   // Only the selected slave's handshake is observed; others may drive anything.
   assign slv_ready = |(apb_pready_i & sel_q);
   assign slv_err   = |(apb_pslverr_i & sel_q);

   always_comb begin
      slv_rdata = '0;
      for (int unsigned i = 0; i < SLV_NUM; i++) begin
         if (idx_q == IDX_W'(i)) slv_rdata = apb_prdata_i[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      idx_d      = idx_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      pstrb_d    = pstrb_q;
      pwrite_d   = pwrite_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      tmo_d      = tmo_q;
      err_code_d = err_code_q;
      err_addr_d = err_addr_q;
      case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (mem_valid_i) begin
               if (dec_hit) begin
                  sel_d    = dec_sel;
                  idx_d    = dec_idx;
                  paddr_d  = mem_addr_i;
                  pwdata_d = mem_wdata_i;
                  pstrb_d  = mem_wstrb_i;
                  pwrite_d = |mem_wstrb_i;
                  state_d  = SETUP;
               end else begin
                  err_d      = 1'b1;
                  rdata_d    = ERR_RDATA;
                  err_code_d = ERR_DEC;
                  err_addr_d = mem_addr_i;
                  state_d    = RESP;
               end
            end
         end
         SETUP: begin
            tmo_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (slv_ready) begin
               state_d = RESP;
               if (slv_err) begin
                  err_d      = 1'b1;
                  rdata_d    = ERR_RDATA;
                  err_code_d = ERR_SLV;
                  err_addr_d = paddr_q;
               end else begin
                  err_d   = 1'b0;
                  rdata_d = pwrite_q ? '0 : slv_rdata;
               end
            end else if (TIMEOUT_CYC > 0) begin
               // tmo_q counts completed wait cycles, so the current cycle is tmo_q+1.
               if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                  err_d      = 1'b1;
                  rdata_d    = ERR_RDATA;
                  err_code_d = ERR_TMO;
                  err_addr_d = paddr_q;
                  state_d    = RESP;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         idx_q      <= '0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         pstrb_q    <= '0;
         pwrite_q   <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         tmo_q      <= '0;
         err_code_q <= ERR_NONE;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         idx_q      <= idx_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         pstrb_q    <= pstrb_d;
         pwrite_q   <= pwrite_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
         err_code_q <= err_code_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign mem_ready_o   = (state_q == RESP);
   assign mem_err_o     = (state_q == RESP) && err_q;
   assign mem_rdata_o   = (state_q == RESP) ? rdata_q : '0;
   assign err_irq_o     = (state_q == RESP) && err_q;
   assign apb_psel_o    = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
   assign apb_penable_o = (state_q == ACCESS);
   assign apb_paddr_o   = paddr_q;
   assign apb_pwdata_o  = pwdata_q;
   assign apb_pstrb_o   = pstrb_q;
   assign apb_pwrite_o  = pwrite_q;
   assign apb_pprot_o   = 3'b000;
   assign err_code_o    = err_code_q;
   assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_mem2apb_bridge_mux.sv
// Directed bench for mem2apb_bridge_mux: 8 slaves at 0x1000_i000, slave 7 an overlapping 64K window.
module tb_mem2apb_bridge_mux;

   localparam logic [7:0][31:0] BASE = {32'h1000_0000, 32'h1000_6000, 32'h1000_5000, 32'h1000_4000,
                                        32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000};
   localparam logic [7:0][31:0] MASK = {32'hFFFF_0000, {7{32'hFFFF_F000}}};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         mem_valid = 1'b0;
   logic [31:0]  mem_addr  = '0;
   logic [31:0]  mem_wdata = '0;
   logic [3:0]   mem_wstrb = '0;
   logic [31:0]  mem_rdata;
   logic         mem_ready, mem_err;
   logic [31:0]  apb_paddr;
   logic [2:0]   apb_pprot;
   logic [7:0]   apb_psel;
   logic         apb_penable, apb_pwrite;
   logic [31:0]  apb_pwdata;
   logic [3:0]   apb_pstrb;
   logic [7:0]   apb_pready, apb_pslverr;
   logic [255:0] apb_prdata;
   logic [1:0]   err_code;
   logic [31:0]  err_addr;
   logic         err_irq;

   int wait_cfg [8];
   bit slverr_cfg [8];
   int acc_cnt = 0;

   int n_chk  = 0;
   int n_pass = 0;

   int          r_lat;
   logic [31:0] r_rdata, r_pwdata, r_paddr;
   logic        r_err, r_irq, r_ok, r_pwrite, r_ready_next, r_irq_next;
   logic [7:0]  r_psel;
   logic [3:0]  r_pstrb;

   always #5 clk = ~clk;

   mem2apb_bridge_mux #(
      .SLV_NUM     (8),
      .ADDR_W      (32),
      .DATA_W      (32),
      .SLV_BASE    (BASE),
      .SLV_MASK    (MASK),
      .TIMEOUT_CYC (4),
      .ERR_RDATA   (32'hDEAD_BEEF)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .mem_valid_i   (mem_valid),
      .mem_addr_i    (mem_addr),
      .mem_wdata_i   (mem_wdata),
      .mem_wstrb_i   (mem_wstrb),
      .mem_rdata_o   (mem_rdata),
      .mem_ready_o   (mem_ready),
      .mem_err_o     (mem_err),
      .apb_paddr_o   (apb_paddr),
      .apb_pprot_o   (apb_pprot),
      .apb_psel_o    (apb_psel),
      .apb_penable_o (apb_penable),
      .apb_pwrite_o  (apb_pwrite),
      .apb_pwdata_o  (apb_pwdata),
      .apb_pstrb_o   (apb_pstrb),
      .apb_pready_i  (apb_pready),
      .apb_prdata_i  (apb_prdata),
      .apb_pslverr_i (apb_pslverr),
      .err_code_o    (err_code),
      .err_addr_o    (err_addr),
      .err_irq_o     (err_irq)
   );

   for (genvar g = 0; g < 8; g++) begin : g_rdata
      assign apb_prdata[g*32 +: 32] = (g == 2) ? 32'h1234_5678 : (32'hA000_0000 | 32'(g));
   end

   always @(posedge clk) acc_cnt <= apb_penable ? acc_cnt + 1 : 0;

   // Unselected slaves drive pready/pslverr high so a wrong-slave pick shows up.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         if (apb_psel[i]) begin
            apb_pready[i]  = apb_penable && (wait_cfg[i] >= 0) && (acc_cnt >= wait_cfg[i]);
            apb_pslverr[i] = apb_pready[i] && slverr_cfg[i];
         end else begin
            apb_pready[i]  = 1'b1;
            apb_pslverr[i] = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task run_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input bit hold);
      bit done, first;
      @(negedge clk);
      mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
      r_lat = -1; r_psel = '0; r_ok = 1'b1; r_rdata = 'x; r_err = 1'bx; r_irq = 1'bx;
      r_pwrite = 1'b0; r_pstrb = '0; r_pwdata = '0; r_paddr = '0;
      first = 1'b1; done = 1'b0;
      for (int k = 1; k <= 40 && !done; k++) begin
         @(negedge clk);
         if (!hold) mem_valid = 1'b0;
         if (apb_psel != '0) begin
            r_psel |= apb_psel;
            if (first) begin
               first = 1'b0;
               r_pwrite = apb_pwrite; r_pstrb = apb_pstrb; r_pwdata = apb_pwdata; r_paddr = apb_paddr;
               if (apb_penable) r_ok = 1'b0;
            end else if (apb_pwrite !== r_pwrite || apb_pstrb !== r_pstrb || apb_pwdata !== r_pwdata ||
                         apb_paddr !== r_paddr || !apb_penable) begin
               r_ok = 1'b0;
            end
         end
         if (mem_ready) begin
            done = 1'b1; r_lat = k;
            r_rdata = mem_rdata; r_err = mem_err; r_irq = err_irq;
            if (apb_psel != '0) r_ok = 1'b0;
         end
      end
      mem_valid = 1'b0;
      @(negedge clk);
      r_ready_next = mem_ready; r_irq_next = err_irq;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin wait_cfg[i] = 0; slverr_cfg[i] = 1'b0; end

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_psel",     apb_psel, 8'h00);
      check("rst_penable",  apb_penable, 1'b0);
      check("rst_ready",    mem_ready, 1'b0);
      check("rst_err_code", err_code, 2'b00);
      check("rst_err_addr", err_addr, 32'h0);
      check("rst_irq",      err_irq, 1'b0);
      check("rst_paddr",    apb_paddr, 32'h0);

      // 1: zero-wait read of slave 2
      run_req(32'h1000_2010, 32'h0, 4'b0000, 1'b1);
      check("t1_lat",   r_lat, 3);
      check("t1_rdata", r_rdata, 32'h1234_5678);
      check("t1_err",   r_err, 1'b0);
      check("t1_psel",  r_psel, 8'h04);
      check("t1_pwrite", r_pwrite, 1'b0);
      check("t1_paddr", r_paddr, 32'h1000_2010);
      check("t1_stable", r_ok, 1'b1);
      check("t1_ready_pulse", r_ready_next, 1'b0);
      check("t1_pprot", apb_pprot, 3'b000);

      // 2: byte-strobed write, slave 0, two wait states, valid dropped early
      wait_cfg[0] = 2;
      run_req(32'h1000_0004, 32'hAABB_CCDD, 4'b0011, 1'b0);
      check("t2_lat",    r_lat, 5);
      check("t2_psel",   r_psel, 8'h01);
      check("t2_pwrite", r_pwrite, 1'b1);
      check("t2_pstrb",  r_pstrb, 4'b0011);
      check("t2_pwdata", r_pwdata, 32'hAABB_CCDD);
      check("t2_stable", r_ok, 1'b1);
      check("t2_rdata",  r_rdata, 32'h0);
      check("t2_err",    r_err, 1'b0);
      check("t2_irq",    r_irq, 1'b0);

      // 3: decode miss
      run_req(32'hF000_0000, 32'h0, 4'b0000, 1'b1);
      check("t3_lat",      r_lat, 1);
      check("t3_psel",     r_psel, 8'h00);
      check("t3_err",      r_err, 1'b1);
      check("t3_rdata",    r_rdata, 32'hDEAD_BEEF);
      check("t3_err_code", err_code, 2'b01);
      check("t3_err_addr", err_addr, 32'hF000_0000);
      check("t3_irq",      r_irq, 1'b1);
      check("t3_irq_next", r_irq_next, 1'b0);

      // 4: PREADY timeout on slave 3
      wait_cfg[3] = -1;
      run_req(32'h1000_3008, 32'h0, 4'b0000, 1'b1);
      check("t4_lat",      r_lat, 6);
      check("t4_err",      r_err, 1'b1);
      check("t4_rdata",    r_rdata, 32'hDEAD_BEEF);
      check("t4_err_code", err_code, 2'b11);
      check("t4_err_addr", err_addr, 32'h1000_3008);
      check("t4_irq",      r_irq, 1'b1);
      check("t4_irq_next", r_irq_next, 1'b0);
      check("t4_psel",     r_psel, 8'h08);

      // 5: PSLVERR from slave 5, then clean requests leave err_code sticky
      slverr_cfg[5] = 1'b1;
      run_req(32'h1000_5000, 32'h0, 4'b0000, 1'b1);
      check("t5_lat",      r_lat, 3);
      check("t5_err",      r_err, 1'b1);
      check("t5_rdata",    r_rdata, 32'hDEAD_BEEF);
      check("t5_err_code", err_code, 2'b10);
      check("t5_irq",      r_irq, 1'b1);
      wait_cfg[7] = 1;
      run_req(32'h1000_8000, 32'h0, 4'b0000, 1'b1);
      check("t5b_lat",      r_lat, 4);
      check("t5b_psel",     r_psel, 8'h80);
      check("t5b_rdata",    r_rdata, 32'hA000_0007);
      check("t5b_err",      r_err, 1'b0);
      check("t5b_err_code", err_code, 2'b10);
      check("t5b_err_addr", err_addr, 32'h1000_5000);
      run_req(32'h1000_6004, 32'h0, 4'b0000, 1'b1);
      check("t5c_psel",  r_psel, 8'h40);
      check("t5c_rdata", r_rdata, 32'hA000_0006);

      // 6: reset during ACCESS
      wait_cfg[1] = -1;
      @(negedge clk);
      mem_valid = 1'b1; mem_addr = 32'h1000_1000; mem_wstrb = 4'b0000;
      @(negedge clk);
      mem_valid = 1'b0;
      @(negedge clk);
      check("t6_in_access", apb_penable, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("t6_psel",     apb_psel, 8'h00);
      check("t6_penable",  apb_penable, 1'b0);
      check("t6_ready",    mem_ready, 1'b0);
      check("t6_err_code", err_code, 2'b00);
      check("t6_err_addr", err_addr, 32'h0);
      rst = 1'b0;
      run_req(32'h1000_2000, 32'h0, 4'b0000, 1'b1);
      check("t6_lat",   r_lat, 3);
      check("t6_rdata", r_rdata, 32'h1234_5678);
      check("t6_err",   r_err, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
